// File: rtl/csr_access_unit.sv
// Initiator side of the CSR register-file port: runs one Zicsr instruction at a time
// through read, read-modify-write and rd writeback of the old CSR value.
module csr_access_unit #(
    parameter int XLEN      = 32,
    parameter int CSR_IDX_W = 12,
    parameter int RD_WAIT   = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [2:0]           i_funct3,
    input  logic [CSR_IDX_W-1:0] i_csr_idx,
    input  logic [4:0]           i_rs1_idx,
    input  logic [XLEN-1:0]      i_rs1_data,
    input  logic [4:0]           i_rd_idx,
    input  logic                 i_flush,
    output logic                 o_csr_ren,
    output logic [CSR_IDX_W-1:0] o_csr_ridx,
    input  logic [XLEN-1:0]      i_csr_rdata,
    output logic                 o_csr_wen,
    output logic [CSR_IDX_W-1:0] o_csr_widx,
    output logic [XLEN-1:0]      o_csr_wdata,
    output logic                 o_wb_valid,
    output logic [4:0]           o_wb_rd_idx,
    output logic [XLEN-1:0]      o_wb_data,
    input  logic                 i_wb_ready,
    output logic                 o_illegal
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_e;

    localparam int CNT_W = (RD_WAIT > 0) ? $clog2(RD_WAIT + 1) : 1;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0]             op_q, op_d;
    logic [CSR_IDX_W-1:0]   idx_q, idx_d;
    logic [XLEN-1:0]        src_q, src_d;
    logic [4:0]             rd_q, rd_d;
    logic                   do_write_q, do_write_d;
    logic [XLEN-1:0]        old_q, old_d;
    logic                   illegal_q, illegal_d;

    logic [XLEN-1:0] src_in;
    logic            rw_in, do_read_in, do_write_in, bad_in, accept;
    logic [XLEN-1:0] new_val;

    // Decode of the offered instruction; zimm forms take the rs1 field as the operand
    assign src_in      = i_funct3[2] ? {{(XLEN-5){1'b0}}, i_rs1_idx} : i_rs1_data;
    assign rw_in       = (i_funct3[1:0] == 2'b01);
    assign do_read_in  = !(rw_in && (i_rd_idx == 5'd0));
    assign do_write_in = rw_in || (i_rs1_idx != 5'd0);
    assign bad_in      = (i_funct3[1:0] == 2'b00) ||
                         (do_write_in && (i_csr_idx[CSR_IDX_W-1 -: 2] == 2'b11));
    assign accept      = (state_q == S_IDLE) && i_valid && !i_flush;

    always_comb begin
        case (op_q)
            2'b10:   new_val = old_q | src_q;
            2'b11:   new_val = old_q & ~src_q;
            default: new_val = src_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            idx_q      <= '0;
            src_q      <= '0;
            rd_q       <= '0;
            do_write_q <= 1'b0;
            old_q      <= '0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            idx_q      <= idx_d;
            src_q      <= src_d;
            rd_q       <= rd_d;
            do_write_q <= do_write_d;
            old_q      <= old_d;
            illegal_q  <= illegal_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        idx_d      = idx_q;
        src_d      = src_q;
        rd_d       = rd_q;
        do_write_d = do_write_q;
        old_d      = old_q;
        illegal_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (bad_in) begin
                        illegal_d = 1'b1;
                    end else begin
                        op_d       = i_funct3[1:0];
                        idx_d      = i_csr_idx;
                        src_d      = src_in;
                        rd_d       = i_rd_idx;
                        do_write_d = do_write_in;
                        old_d      = '0;
                        cnt_d      = '0;
                        state_d    = do_read_in ? S_READ : S_WRITE;
                    end
                end
            end
            S_READ: begin
                if (i_flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(RD_WAIT)) begin
                    old_d   = i_csr_rdata;
                    state_d = S_WRITE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // The write is issued in this cycle regardless of flush; only the response is dropped
            S_WRITE: state_d = (i_flush || (rd_q == 5'd0)) ? S_IDLE : S_RESP;
            S_RESP:  if (i_flush || i_wb_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_ready     = (state_q == S_IDLE);
        o_csr_ren   = 1'b0;
        o_csr_ridx  = '0;
        o_csr_wen   = 1'b0;
        o_csr_widx  = '0;
        o_csr_wdata = '0;
        o_wb_valid  = 1'b0;
        o_wb_rd_idx = '0;
        o_wb_data   = '0;
        case (state_q)
            S_READ: begin
                o_csr_ren  = 1'b1;
                o_csr_ridx = idx_q;
            end
            S_WRITE: begin
                o_csr_wen   = do_write_q;
                o_csr_widx  = do_write_q ? idx_q : '0;
                o_csr_wdata = do_write_q ? new_val : '0;
            end
            S_RESP: begin
                o_wb_valid  = !i_flush;
                o_wb_rd_idx = rd_q;
                o_wb_data   = old_q;
            end
            default: ;
        endcase
    end

    assign o_illegal = illegal_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Randomized bench for csr_access_unit: a CSR file model answers the port and a
// transaction-level reference predicts accesses, writeback, latency and flush effects.
module tb_csr_access_unit;

    localparam int RD_WAIT = 1;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_funct3;
    logic [11:0] i_csr_idx;
    logic [4:0]  i_rs1_idx;
    logic [31:0] i_rs1_data;
    logic [4:0]  i_rd_idx;
    logic        i_flush;
    logic        o_csr_ren;
    logic [11:0] o_csr_ridx;
    logic [31:0] i_csr_rdata;
    logic        o_csr_wen;
    logic [11:0] o_csr_widx;
    logic [31:0] o_csr_wdata;
    logic        o_wb_valid;
    logic [4:0]  o_wb_rd_idx;
    logic [31:0] o_wb_data;
    logic        i_wb_ready;
    logic        o_illegal;

    int n_tests = 0;
    int n_fail  = 0;

    csr_access_unit #(.XLEN(32), .CSR_IDX_W(12), .RD_WAIT(RD_WAIT)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .o_ready(o_ready),
        .i_funct3(i_funct3), .i_csr_idx(i_csr_idx), .i_rs1_idx(i_rs1_idx),
        .i_rs1_data(i_rs1_data), .i_rd_idx(i_rd_idx), .i_flush(i_flush),
        .o_csr_ren(o_csr_ren), .o_csr_ridx(o_csr_ridx), .i_csr_rdata(i_csr_rdata),
        .o_csr_wen(o_csr_wen), .o_csr_widx(o_csr_widx), .o_csr_wdata(o_csr_wdata),
        .o_wb_valid(o_wb_valid), .o_wb_rd_idx(o_wb_rd_idx), .o_wb_data(o_wb_data),
        .i_wb_ready(i_wb_ready), .o_illegal(o_illegal)
    );

    always #5 i_clk = ~i_clk;

    // CSR file seen by the DUT: power-up contents from init_val, overwritten by wen
    logic [31:0] mem    [0:4095];
    bit          wr_ok  [0:4095];
    logic [31:0] ref_mem[0:4095];

    function automatic logic [31:0] init_val(input logic [11:0] idx);
        case (idx)
            12'h305: init_val = 32'h0000_0000;
            12'h304: init_val = 32'h0000_0008;
            12'h310: init_val = 32'h0000_0007;
            default: init_val = {idx, 4'h0, idx ^ 12'hA5C, 4'h3};
        endcase
    endfunction

    function automatic logic [31:0] csr_value(input logic [11:0] idx);
        csr_value = wr_ok[idx] ? mem[idx] : init_val(idx);
    endfunction

    always @(posedge i_clk) begin
        if (o_csr_wen) begin
            mem[o_csr_widx]   <= o_csr_wdata;
            wr_ok[o_csr_widx] <= 1'b1;
        end
    end

    always_comb begin
        i_csr_rdata = 32'h0;
        if (o_csr_ren) i_csr_rdata = wr_ok[o_csr_ridx] ? mem[o_csr_ridx] : init_val(o_csr_ridx);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // fmode: 0 none, 1 flush during read, 2 flush during write, 3 flush during response
    task automatic run_txn(input logic [2:0] f3, input logic [11:0] idx, input logic [4:0] rs1,
                           input logic [31:0] data, input logic [4:0] rd,
                           input int stall, input int fmode);
        logic        rw, legal, dr, dw;
        logic [31:0] src, oldv, newv;
        int mode, exp_ren, exp_wen, exp_wb, exp_ready, base;
        int ren_n, wen_n, wb_n, ill_n, first_ready;
        bit done, flushed, s_ren, s_wen, s_wb;

        rw    = (f3[1:0] == 2'b01);
        src   = f3[2] ? {27'd0, rs1} : data;
        dr    = !(rw && rd == 5'd0);
        dw    = rw || rs1 != 5'd0;
        legal = (f3[1:0] != 2'b00) && !(dw && idx[11:10] == 2'b11);
        oldv  = dr ? ref_mem[idx] : 32'h0;
        case (f3[1:0])
            2'b10:   newv = oldv | src;
            2'b11:   newv = oldv & ~src;
            default: newv = src;
        endcase
        mode = fmode;
        if (!legal || (mode == 1 && !dr) || (mode == 2 && !dw) || (mode == 3 && rd == 5'd0)) mode = 0;

        exp_ren = (legal && dr) ? ((mode == 1) ? 1 : RD_WAIT + 1) : 0;
        exp_wen = (legal && dw && mode != 1) ? 1 : 0;
        exp_wb  = (legal && rd != 5'd0 && mode == 0) ? stall + 1 : ((mode == 3) ? 1 : 0);
        base    = 2 + (dr ? RD_WAIT + 1 : 0);
        if (!legal)                          exp_ready = 1;
        else if (mode == 1)                  exp_ready = 2;
        else if (rd == 5'd0 || mode == 2)    exp_ready = base;
        else if (mode == 3)                  exp_ready = base + 1;
        else                                 exp_ready = base + 1 + stall;

        chk("ready_before_accept", 32'(o_ready), 32'd1);
        i_valid = 1'b1; i_funct3 = f3; i_csr_idx = idx; i_rs1_idx = rs1;
        i_rs1_data = data; i_rd_idx = rd; i_wb_ready = 1'b0;
        @(posedge i_clk);
        ren_n = 0; wen_n = 0; wb_n = 0; ill_n = 0; first_ready = 0; done = 0; flushed = 0;
        for (int k = 1; k <= 60 && !done; k++) begin
            @(negedge i_clk);
            s_ren = o_csr_ren; s_wen = o_csr_wen; s_wb = o_wb_valid;
            chk("ren_wen_excl", 32'(o_csr_ren & o_csr_wen), 32'd0);
            if (s_ren) begin
                ren_n++;
                chk("ridx", 32'(o_csr_ridx), 32'(idx));
            end else chk("ridx_idle", 32'(o_csr_ridx), 32'd0);
            if (s_wen) begin
                wen_n++;
                chk("widx", 32'(o_csr_widx), 32'(idx));
                chk("wdata", o_csr_wdata, newv);
            end else begin
                chk("widx_idle", 32'(o_csr_widx), 32'd0);
                chk("wdata_idle", o_csr_wdata, 32'd0);
            end
            if (s_wb) begin
                wb_n++;
                chk("wb_rd", 32'(o_wb_rd_idx), 32'(rd));
                chk("wb_data", o_wb_data, oldv);
            end
            if (o_illegal) ill_n++;
            if (o_ready && first_ready == 0) first_ready = k;
            done = (first_ready != 0) && (k >= 2);
            i_valid = 1'b0;
            i_flush = 1'b0;
            if (mode == 1 && !flushed && s_ren) begin
                i_flush = 1'b1; flushed = 1;
            end else if (mode == 2 && !flushed && s_wen) begin
                i_flush = 1'b1; flushed = 1;
            end else if (mode == 3 && !flushed && s_wb) begin
                i_flush = 1'b1; flushed = 1; i_wb_ready = 1'b0;
                #1 chk("wb_drop_on_flush", 32'(o_wb_valid), 32'd0);
            end else if (s_wb) begin
                i_wb_ready = (wb_n > stall);
            end
        end
        if (!done) chk("timeout", 32'd1, 32'd0);
        i_wb_ready = 1'b0;
        i_flush    = 1'b0;
        if (exp_wen != 0) ref_mem[idx] = newv;
        chk("ren_cycles", 32'(ren_n), 32'(exp_ren));
        chk("wen_count", 32'(wen_n), 32'(exp_wen));
        chk("wb_cycles", 32'(wb_n), 32'(exp_wb));
        chk("illegal_pulses", 32'(ill_n), legal ? 32'd0 : 32'd1);
        chk("ready_latency", 32'(first_ready), 32'(exp_ready));
        chk("csr_contents", csr_value(idx), ref_mem[idx]);
    endtask

    logic [2:0]  f3_tab  [6] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
    logic [11:0] idx_tab [9] = '{12'h305, 12'h304, 12'h310, 12'h340, 12'h312,
                                 12'hC00, 12'hC01, 12'h7C0, 12'hF11};

    initial begin
        logic [2:0]  f3;
        logic [4:0]  rs1, rd;
        int          r;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(12'(i));
        i_rstn = 1'b0; i_valid = 1'b0; i_funct3 = '0; i_csr_idx = '0; i_rs1_idx = '0;
        i_rs1_data = '0; i_rd_idx = '0; i_flush = 1'b0; i_wb_ready = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_ren", 32'(o_csr_ren), 32'd0);
        chk("rst_wen", 32'(o_csr_wen), 32'd0);
        chk("rst_wb_valid", 32'(o_wb_valid), 32'd0);
        chk("rst_wb_data", o_wb_data, 32'd0);
        chk("rst_illegal", 32'(o_illegal), 32'd0);
        i_rstn = 1'b1;
        @(negedge i_clk);

        run_txn(3'b001, 12'h305, 5'd10, 32'h8000_0100, 5'd5, 0, 0);
        run_txn(3'b010, 12'h304, 5'd3,  32'h0000_0088, 5'd6, 0, 0);
        chk("csrrs_result", ref_mem[12'h304], 32'h0000_0088);
        run_txn(3'b010, 12'h304, 5'd0,  32'hFFFF_FFFF, 5'd6, 0, 0);
        run_txn(3'b111, 12'h310, 5'd3,  32'h0,         5'd7, 0, 0);
        chk("csrrci_result", ref_mem[12'h310], 32'h0000_0004);
        run_txn(3'b001, 12'h312, 5'd4,  32'h1234_5678, 5'd0, 0, 0);
        run_txn(3'b100, 12'h305, 5'd1,  32'h1,         5'd1, 0, 0);
        run_txn(3'b001, 12'hC00, 5'd1,  32'h1,         5'd1, 0, 0);
        run_txn(3'b010, 12'h340, 5'd2,  32'hF0F0_0000, 5'd8, 0, 1);
        run_txn(3'b001, 12'h340, 5'd2,  32'h0BAD_F00D, 5'd9, 3, 0);
        run_txn(3'b011, 12'h341, 5'd4,  32'h0000_00FF, 5'd10, 0, 2);
        run_txn(3'b110, 12'h342, 5'd5,  32'h0,         5'd11, 0, 3);

        // Flush offered together with an instruction must swallow it
        i_valid = 1'b1; i_flush = 1'b1; i_funct3 = 3'b001; i_csr_idx = 12'h340;
        i_rs1_idx = 5'd1; i_rs1_data = 32'hDEAD_BEEF; i_rd_idx = 5'd5;
        @(negedge i_clk);
        i_valid = 1'b0; i_flush = 1'b0;
        repeat (4) begin
            chk("flush_accept_ready", 32'(o_ready), 32'd1);
            chk("flush_accept_access", 32'(o_csr_ren | o_csr_wen | o_wb_valid | o_illegal), 32'd0);
            @(negedge i_clk);
        end
        chk("flush_accept_csr", csr_value(12'h340), ref_mem[12'h340]);

        // Reset in the middle of a read
        i_valid = 1'b1; i_funct3 = 3'b010; i_csr_idx = 12'h304; i_rs1_idx = 5'd1;
        i_rs1_data = 32'h1; i_rd_idx = 5'd3;
        @(negedge i_clk);
        i_valid = 1'b0;
        chk("midrst_ren_before", 32'(o_csr_ren), 32'd1);
        #2 i_rstn = 1'b0;
        #1 chk("midrst_ren_drop", 32'(o_csr_ren), 32'd0);
        chk("midrst_ready", 32'(o_ready), 32'd1);
        chk("midrst_wen", 32'(o_csr_wen), 32'd0);
        @(negedge i_clk);
        i_rstn = 1'b1;
        @(negedge i_clk);
        chk("midrst_csr", csr_value(12'h304), ref_mem[12'h304]);

        for (int t = 0; t < 250; t++) begin
            r = int'($urandom_range(0, 15));
            if (r == 0)      f3 = 3'b000;
            else if (r == 1) f3 = 3'b100;
            else             f3 = f3_tab[$urandom_range(0, 5)];
            rs1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            r   = int'($urandom_range(0, 7));
            run_txn(f3, idx_tab[$urandom_range(0, 8)], rs1, $urandom, rd,
                    int'($urandom_range(0, 3)), (r > 3) ? 0 : r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
